// File: rtl/uart_tx_pkg.sv
// Shared types and line-level constants for the UART transmit framer.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LINE = 1'b1;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Parity bit generator: XOR-reduce of the data word, inverted for odd parity.
module uart_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_par_typ,
  output logic                  o_parity
);

  assign o_parity = (^i_data) ^ (i_par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start, LSB-first data, optional parity, stop.
// One CLK period is one bit time; outputs are registered from next state.
module uart_tx_frame
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_e             r_state;
  tx_state_e             w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [CNT_W-1:0]      w_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  w_load;
  logic                  w_parity;
  logic                  w_tx_nxt;
  logic                  w_busy_nxt;

  uart_parity_calc #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_parity (
    .i_data   (r_data),
    .i_par_typ(r_par_typ),
    .o_parity (w_parity)
  );

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_load    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (Data_Valid) begin
          w_next = START;
          w_load = 1'b1;
        end
      end
      START: begin
        w_next    = DATA;
        w_cnt_nxt = '0;
      end
      DATA: begin
        if (r_cnt == LAST_BIT) begin
          w_next    = r_par_en ? PARITY : STOP;
          w_cnt_nxt = '0;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      PARITY: w_next = STOP;
      STOP:   w_next = IDLE;
      default: begin
        w_next    = IDLE;
        w_cnt_nxt = '0;
      end
    endcase

    // Line value for the state being entered on this edge.
    w_tx_nxt = IDLE_LINE;
    unique case (w_next)
      IDLE:    w_tx_nxt = IDLE_LINE;
      START:   w_tx_nxt = START_BIT;
      DATA:    w_tx_nxt = r_data[w_cnt_nxt];
      PARITY:  w_tx_nxt = w_parity;
      STOP:    w_tx_nxt = STOP_BIT;
      default: w_tx_nxt = IDLE_LINE;
    endcase
    w_busy_nxt = (w_next != IDLE);
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      r_cnt     <= '0;
      r_data    <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
      TX_OUT    <= IDLE_LINE;
      Busy      <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_nxt;
      TX_OUT <= w_tx_nxt;
      Busy   <= w_busy_nxt;
      if (w_load) begin
        r_data    <= P_DATA;
        r_par_en  <= PAR_EN;
        r_par_typ <= PAR_TYP;
      end
    end
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
UART transmit framer clocked directly by the divided clock from the clock-divider stage. One CLK period is one bit time.
Accepts a parallel byte with a valid strobe and serialises it as start, data LSB-first, optional parity, then stop. It drives the idle-high serial line and a Busy flag back to the register/control block that supplies data.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (supported range 5..8)

Ports:
CLK  in  1  bit-rate clock, the output of the clock divider; all logic is on the rising edge
Reset  in  1  asynchronous, active-high; clears all state immediately
P_DATA  in  DATA_WIDTH  parallel data to transmit
Data_Valid  in  1  request strobe; sampled only in IDLE
PAR_EN  in  1  1 = insert parity bit
PAR_TYP  in  1  0 = even parity, 1 = odd parity
TX_OUT  out  1  serial line; registered; idle high
Busy  out  1  high while a frame is on the line; registered

Behaviour:
- One clock, CLK. Reset is asynchronous and active-high.
- Reset asserted (any time, including mid-frame):
  - state goes to IDLE;
  - TX_OUT=1 and Busy=0 with no clock edge required;
  - bit counter=0, data and parity-config latches=0.
- FSM states: IDLE, START, DATA, PARITY, STOP. All outputs are registered from the next-state decode, so they change on the edge that enters a state.
- IDLE:
  - TX_OUT=1, Busy=0.
  - If Data_Valid=1 at a rising edge: latch P_DATA, PAR_EN and PAR_TYP, then go to START.
  - Otherwise stay in IDLE.
- START: TX_OUT=0, Busy=1, lasts exactly 1 cycle, then DATA with bit counter=0.
- DATA:
  - TX_OUT = latched_data[counter], LSB first.
  - Counter increments each cycle, so the state lasts DATA_WIDTH cycles.
  - After bit DATA_WIDTH-1: go to PARITY if latched PAR_EN=1, else STOP.
  - The counter is $clog2(DATA_WIDTH) bits wide with no wrap inside the state; it is cleared on leaving DATA.
- PARITY:
  - TX_OUT = XOR-reduce(latched_data) XOR latched PAR_TYP, so even parity gives total ones count even.
  - Lasts 1 cycle, then STOP.
- STOP: TX_OUT=1, Busy=1, lasts 1 cycle, then IDLE.
- Frame length from start-bit edge to end of stop bit: DATA_WIDTH+2 cycles, or +3 with parity.
- Latency: the start bit appears on TX_OUT at the same edge that samples Data_Valid=1 in IDLE.
- Data_Valid, P_DATA, PAR_EN and PAR_TYP are ignored while Busy=1. Changing them mid-frame must not affect the frame in flight.
- Back-to-back: with Data_Valid held high, after STOP the block spends exactly one IDLE cycle (TX_OUT=1, Busy=0), then starts the next frame. The minimum inter-frame gap is therefore stop + 1 idle bit.
- Reset released mid-frame: the block resumes in IDLE. No partial frame continues and there is no glitch low on TX_OUT.
- A gated or stopped CLK (divider disabled) freezes the FSM in place. The block needs no special handling for this.

Decomposition:
- Package uart_tx_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - constants START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LINE=1'b1;
  - constants PAR_EVEN=1'b0, PAR_ODD=1'b1.
- One sub-module, uart_parity_calc: combinational DATA_WIDTH-input XOR-reduce plus PAR_TYP select, instantiated on the latched data.
- The serial mux and FSM stay in uart_tx_frame.

Test Plan:
1. Reset held, then released with Data_Valid=0 for 20 cycles -> TX_OUT=1 and Busy=0 throughout.
2. P_DATA=8'hA5, PAR_EN=0, one-cycle Data_Valid -> TX_OUT = 0,1,0,1,0,0,1,0,1,1 over 10 cycles; Busy=1 for exactly those 10 cycles, then 0.
3. P_DATA=8'hA5, PAR_EN=1: with PAR_TYP=0 the parity bit is 0; with PAR_TYP=1 it is 1. P_DATA=8'h01 even -> parity bit 1. Each frame is 11 cycles.
4. Data_Valid held high with P_DATA=8'h3C, changed to 8'hFF mid-frame -> first frame carries 3C. Exactly one idle-high non-busy cycle follows, then a frame carrying FF.
5. Reset pulsed during DATA bit 4 of 8'h00 -> TX_OUT=1 and Busy=0 immediately without a clock edge. The next accepted frame (8'h55) is fully correct.
6. Divider output stopped for 50 reference cycles mid-frame, then restarted -> the frame resumes from the same bit with no lost or repeated bits.
